// File: rtl/led_mode_scheduler.sv
// Mode/colour sequencer for the LED pattern engines: debounced buttons, run/pause and an auto playlist.
// Define LED_SCHED_BOUNCE_EN to make mode advances ping-pong (00-01-10-01-00) instead of wrapping.
module led_mode_scheduler #(
   parameter int NB_BTN    = 4,
   parameter int NB_DWELL  = 8,
   parameter int DB_CYCLES = 1000000
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic [NB_BTN-1:0]   i_btn,
   input  logic [NB_DWELL-1:0] i_dwell,
   output logic [1:0]          o_mode,
   output logic [2:0]          o_color,
   output logic                o_enable,
   output logic                o_run,
   output logic                o_auto,
   output logic                o_mode_change
);

   localparam int               CNT_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      PAUSE    = 2'd0,
      RUN_MAN  = 2'd1,
      RUN_AUTO = 2'd2
   } state_t;

   logic [1:0]          r_rst_sync;
   logic                w_rst_n;
   logic [NB_BTN-1:0]   r_btn_s1;
   logic [NB_BTN-1:0]   r_btn_s2;
   logic [NB_BTN-1:0]   r_btn_db;
   logic [NB_BTN-1:0]   r_btn_db_d;
   logic [CNT_W-1:0]    r_db_cnt [NB_BTN];
   logic [NB_BTN-1:0]   w_press;
   state_t              r_state;
   state_t              w_state_next;
   logic                r_auto;
   logic                w_auto_next;
   logic [1:0]          r_mode;
   logic [1:0]          w_mode_next;
   logic [2:0]          r_color;
   logic                r_mode_change;
   logic [NB_DWELL-1:0] r_dwell;
   logic [NB_DWELL-1:0] w_limit_m1;
   logic                w_expire;
   logic                w_advance;
   logic                w_auto_entry;

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_btn_s1   <= '0;
         r_btn_s2   <= '0;
         r_btn_db_d <= '0;
      end else begin
         r_btn_s1   <= i_btn;
         r_btn_s2   <= r_btn_s1;
         r_btn_db_d <= r_btn_db;
      end
   end

   // A level is accepted only after DB_CYCLES consecutive cycles of disagreement.
   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_btn_db <= '0;
         for (int b = 0; b < NB_BTN; b++) begin
            r_db_cnt[b] <= '0;
         end
      end else begin
         for (int b = 0; b < NB_BTN; b++) begin
            if (r_btn_s2[b] == r_btn_db[b]) begin
               r_db_cnt[b] <= '0;
            end else if (r_db_cnt[b] == DB_LAST) begin
               r_db_cnt[b] <= '0;
               r_btn_db[b] <= r_btn_s2[b];
            end else begin
               r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
            end
         end
      end
   end

   assign w_press      = r_btn_db & ~r_btn_db_d;
   assign w_limit_m1   = (i_dwell == '0) ? '0 : i_dwell - 1'b1;
   assign w_expire     = (r_state == RUN_AUTO) && i_valid && (r_dwell >= w_limit_m1);
   assign w_advance    = w_press[0] | w_expire;
   assign w_auto_entry = w_press[3] & ~r_auto;

   always_comb begin
      w_auto_next  = r_auto ^ w_press[3];
      w_state_next = r_state;
      case (r_state)
         PAUSE: begin
            if (w_press[1]) begin
               w_state_next = w_auto_next ? RUN_AUTO : RUN_MAN;
            end
         end
         RUN_MAN, RUN_AUTO: begin
            if (w_press[1]) begin
               w_state_next = PAUSE;
            end else begin
               w_state_next = w_auto_next ? RUN_AUTO : RUN_MAN;
            end
         end
         default: w_state_next = RUN_MAN;
      endcase
   end

`ifdef LED_SCHED_BOUNCE_EN
   logic r_dir_up;
   logic w_dir_next;

   // Direction turns around whenever the step lands on either end mode.
   always_comb begin
      w_mode_next = r_mode;
      w_dir_next  = r_dir_up;
      if (w_advance) begin
         if (r_dir_up) begin
            w_mode_next = r_mode + 2'd1;
            w_dir_next  = (r_mode == 2'd1) ? 1'b0 : 1'b1;
         end else begin
            w_mode_next = r_mode - 2'd1;
            w_dir_next  = (r_mode == 2'd1) ? 1'b1 : 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_dir_up <= 1'b1;
      end else begin
         r_dir_up <= w_dir_next;
      end
   end
`else
   always_comb begin
      w_mode_next = r_mode;
      if (w_advance) begin
         w_mode_next = (r_mode == 2'd2) ? 2'd0 : r_mode + 2'd1;
      end
   end
`endif

   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state       <= RUN_MAN;
         r_auto        <= 1'b0;
         r_mode        <= 2'd0;
         r_color       <= 3'b001;
         r_mode_change <= 1'b0;
         r_dwell       <= '0;
      end else begin
         r_state       <= w_state_next;
         r_auto        <= w_auto_next;
         r_mode        <= w_mode_next;
         r_mode_change <= w_advance;
         if (w_press[2]) begin
            r_color <= {r_color[1:0], r_color[2]};
         end
         if (w_advance || w_auto_entry) begin
            r_dwell <= '0;
         end else if ((r_state == RUN_AUTO) && i_valid) begin
            r_dwell <= r_dwell + 1'b1;
         end
      end
   end

   assign o_mode        = r_mode;
   assign o_color       = r_color;
   assign o_run         = (r_state != PAUSE);
   assign o_auto        = r_auto;
   assign o_mode_change = r_mode_change;
   assign o_enable      = i_valid & o_run & w_rst_n;

endmodule
